// File: rtl/bridge_pkg.sv
// Shared types for the Avalon burst to asynchronous SRAM bridge.
// Defining SRAM_BRIDGE_TURNAROUND_EN adds the TURN state.
package bridge_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_PULSE = 3'd2,
      WR_REC   = 3'd3
`ifdef SRAM_BRIDGE_TURNAROUND_EN
      ,
      TURN     = 3'd4
`endif
   } state_t;

   // Active-low lane strobes: all lanes on / all lanes off.
   localparam logic [3:0] BE_ALL  = 4'h0;
   localparam logic [3:0] BE_NONE = 4'hF;

   function automatic int access_len(input int wait_cycles);
      return wait_cycles + 1;
   endfunction

   function automatic int cnt_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Counts the cycles of one SRAM access, 0..T-1, flagging the last one.
// Restarts from zero on start and wraps while run is held.
module sram_wait_counter
   import bridge_pkg::*;
#(
   parameter int T = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic run,
   output logic last
);

   localparam int CW = cnt_width(T);
   localparam logic [CW-1:0] LAST_CNT = CW'(T - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

   assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/avalon_burst_sram_bridge.sv
// Avalon-MM burst slave driving a 32-bit async SRAM, one word per access.
// Optional SRAM_BRIDGE_TURNAROUND_EN inserts a TURN cycle after each burst.
module avalon_burst_sram_bridge
   import bridge_pkg::*;
#(
   parameter int ADDR_WIDTH      = 32,
   parameter int BURST_WIDTH     = 7,
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int WAIT_CYCLES     = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [ADDR_WIDTH-1:0]      avs_address,
   input  logic [BURST_WIDTH-1:0]     avs_burstcount,
   input  logic                       avs_read,
   input  logic                       avs_write,
   input  logic [31:0]                avs_writedata,
   input  logic [3:0]                 avs_byteenable,
   output logic [31:0]                avs_readdata,
   output logic                       avs_readdatavalid,
   output logic                       avs_waitrequest,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]                sram_dq_o,
   input  logic [31:0]                sram_dq_i,
   output logic                       sram_dq_oe,
   output logic                       sram_ce_n,
   output logic                       sram_oe_n,
   output logic                       sram_we_n,
   output logic [3:0]                 sram_be_n
);

   localparam int T = access_len(WAIT_CYCLES);

`ifdef SRAM_BRIDGE_TURNAROUND_EN
   localparam state_t DONE = TURN;
`else
   localparam state_t DONE = IDLE;
`endif

   state_t                     state;
   logic [BURST_WIDTH-1:0]     beats;
   logic [SRAM_ADDR_WIDTH-1:0] word;
   logic [BURST_WIDTH-1:0]     count;
   logic                       more;
   logic                       idle_rd;
   logic                       idle_wr;
   logic                       rec_wr;
   logic                       start;
   logic                       run;
   logic                       last;
   logic                       unused;

   assign word  = avs_address[SRAM_ADDR_WIDTH+1:2];
   assign count = (avs_burstcount == '0) ? BURST_WIDTH'(1) : avs_burstcount;
   assign more  = (beats != '0);

   // Read wins when both requests arrive together in IDLE.
   assign idle_rd = (state == IDLE) && avs_read;
   assign idle_wr = (state == IDLE) && !avs_read && avs_write;
   assign rec_wr  = (state == WR_REC) && more && avs_write;

   assign start = idle_rd | idle_wr | rec_wr;
   assign run   = (state == RD) || (state == WR_PULSE);

   assign unused = ^{avs_address[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2],
                     avs_address[1:0]};

   sram_wait_counter #(
      .T(T)
   ) u_wait (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .run  (run),
      .last (last)
   );

   always_comb begin
      avs_waitrequest = 1'b1;
      if (!rst_n) begin
         avs_waitrequest = 1'b1;
      end else if (state == IDLE) begin
         avs_waitrequest = !(avs_read || avs_write);
      end else if ((state == WR_REC) && more) begin
         avs_waitrequest = !avs_write;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         beats             <= '0;
         sram_addr         <= '0;
         sram_dq_o         <= '0;
         sram_dq_oe        <= 1'b0;
         sram_ce_n         <= 1'b1;
         sram_oe_n         <= 1'b1;
         sram_we_n         <= 1'b1;
         sram_be_n         <= BE_NONE;
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (idle_rd) begin
                  state     <= RD;
                  sram_addr <= word;
                  beats     <= count;
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
                  sram_be_n <= BE_ALL;
               end else if (idle_wr) begin
                  state      <= WR_PULSE;
                  sram_addr  <= word;
                  beats      <= count - 1'b1;
                  sram_dq_o  <= avs_writedata;
                  sram_be_n  <= ~avs_byteenable;
                  sram_ce_n  <= 1'b0;
                  sram_we_n  <= 1'b0;
                  sram_dq_oe <= 1'b1;
               end
            end
            RD: begin
               // Next beat's access overlaps the strobe of this one.
               if (last) begin
                  avs_readdatavalid <= 1'b1;
                  avs_readdata      <= sram_dq_i;
                  if (beats == BURST_WIDTH'(1)) begin
                     state     <= DONE;
                     beats     <= '0;
                     sram_ce_n <= 1'b1;
                     sram_oe_n <= 1'b1;
                     sram_be_n <= BE_NONE;
                  end else begin
                     beats     <= beats - 1'b1;
                     sram_addr <= sram_addr + 1'b1;
                  end
               end
            end
            WR_PULSE: begin
               if (last) begin
                  state     <= WR_REC;
                  sram_we_n <= 1'b1;
               end
            end
            WR_REC: begin
               if (!more) begin
                  state      <= DONE;
                  sram_ce_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  sram_be_n  <= BE_NONE;
               end else if (avs_write) begin
                  state      <= WR_PULSE;
                  sram_addr  <= sram_addr + 1'b1;
                  beats      <= beats - 1'b1;
                  sram_dq_o  <= avs_writedata;
                  sram_be_n  <= ~avs_byteenable;
                  sram_ce_n  <= 1'b0;
                  sram_we_n  <= 1'b0;
                  sram_dq_oe <= 1'b1;
               end else begin
                  // Master stalled mid-burst: park the bus until it returns.
                  sram_ce_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  sram_be_n  <= BE_NONE;
               end
            end
`ifdef SRAM_BRIDGE_TURNAROUND_EN
            TURN: begin
               state <= IDLE;
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_burst_sram_bridge.sv
// Scoreboard bench for avalon_burst_sram_bridge against a behavioural SRAM.
// Works with or without SRAM_BRIDGE_TURNAROUND_EN.
module tb_avalon_burst_sram_bridge;

   localparam int AW = 32;
   localparam int BW = 7;
   localparam int SW = 20;
   localparam int WC = 1;
   localparam int T  = WC + 1;
   localparam int unsigned WMASK = (1 << SW) - 1;
`ifdef SRAM_BRIDGE_TURNAROUND_EN
   localparam int TURN_CYC = 1;
`else
   localparam int TURN_CYC = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] avs_address = '0;
   logic [BW-1:0] avs_burstcount = '0;
   logic          avs_read = 1'b0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [3:0]    avs_byteenable = '0;
   logic [31:0]   avs_readdata;
   logic          avs_readdatavalid;
   logic          avs_waitrequest;
   logic [SW-1:0] sram_addr;
   logic [31:0]   sram_dq_o;
   logic [31:0]   sram_dq_i;
   logic          sram_dq_oe;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic [3:0]    sram_be_n;

   always #5 clk = ~clk;

   avalon_burst_sram_bridge #(
      .ADDR_WIDTH(AW),
      .BURST_WIDTH(BW),
      .SRAM_ADDR_WIDTH(SW),
      .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .avs_address(avs_address),
      .avs_burstcount(avs_burstcount),
      .avs_read(avs_read),
      .avs_write(avs_write),
      .avs_writedata(avs_writedata),
      .avs_byteenable(avs_byteenable),
      .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid),
      .avs_waitrequest(avs_waitrequest),
      .sram_addr(sram_addr),
      .sram_dq_o(sram_dq_o),
      .sram_dq_i(sram_dq_i),
      .sram_dq_oe(sram_dq_oe),
      .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n),
      .sram_be_n(sram_be_n)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: unwritten words hold a fixed hash of their address.
   bit [31:0] sram [0:(1<<SW)-1];
   bit        written [0:(1<<SW)-1];

   function automatic logic [31:0] init_word(input int unsigned a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h3C5AA5C3;
   endfunction

   function automatic logic [31:0] sram_cur(input int unsigned a);
      return written[a] ? sram[a] : init_word(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++)
         if (be[k]) r[8*k +: 8] = d[8*k +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
         sram[sram_addr]    <= merge(sram_cur(sram_addr), sram_dq_o, ~sram_be_n);
         written[sram_addr] <= 1'b1;
      end
      sram_dq_i <= (!sram_ce_n && !sram_oe_n) ? sram_cur(sram_addr) : 32'h0;
   end

   // Reference model: word-addressed memory and expected read queue.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] exp_q [$];
   logic [SW-1:0] addr_log [$];
   logic [3:0] be_log [$];
   logic [3:0] be_plan [$];
   int rdv_cnt = 0;
   int last_rdv_cyc = 0;
   int we_pulses = 0;
   int we_low = 0;
   logic we_prev = 1'b1;

   function automatic logic [31:0] ref_rd(input int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every read strobe.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && avs_readdatavalid) begin
            rdv_cnt++;
            last_rdv_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rd_unexpected: got %h want none", avs_readdata);
            end else begin
               e = exp_q.pop_front();
               if (avs_readdata !== e) begin
                  bad++;
                  $display("FAIL rd_data: got %h want %h", avs_readdata, e);
               end
            end
         end
         if (!sram_ce_n && !sram_oe_n &&
             (addr_log.size() == 0 || addr_log[$] != sram_addr))
            addr_log.push_back(sram_addr);
         if (!sram_we_n) begin
            we_low++;
            if (we_prev) begin
               we_pulses++;
               be_log.push_back(sram_be_n);
            end
         end
         we_prev = sram_we_n;
      end
   end

   task automatic wait_accept(output int acc);
      acc = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!avs_waitrequest) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got waitrequest=1 want 0");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic [31:0] addr, input int bc, output int acc);
      int n;
      int unsigned w;
      n = (bc == 0) ? 1 : bc;
      w = int'(addr[SW+1:2]);
      for (int i = 0; i < n; i++)
         exp_q.push_back(ref_rd((w + i) & WMASK));
      avs_address = addr;
      avs_burstcount = BW'(bc);
      avs_read = 1'b1;
      wait_accept(acc);
      avs_read = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input int bc,
                           input int stall_beat, input int stall_len,
                           output int acc0);
      int n;
      int acc;
      int unsigned w;
      int unsigned a;
      logic [31:0] d;
      logic [3:0] b;
      n = (bc == 0) ? 1 : bc;
      w = int'(addr[SW+1:2]);
      acc0 = -1;
      for (int i = 0; i < n; i++) begin
         d = $urandom;
         b = (be_plan.size() != 0) ? be_plan.pop_front() : 4'($urandom_range(0, 15));
         if (i == stall_beat && stall_len > 0) begin
            avs_write = 1'b0;
            repeat (stall_len) @(posedge clk);
            #1;
         end
         avs_address = addr;
         avs_burstcount = BW'(bc);
         avs_writedata = d;
         avs_byteenable = b;
         avs_write = 1'b1;
         wait_accept(acc);
         if (i == 0) acc0 = acc;
         a = (w + i) & WMASK;
         ref_mem[a] = merge(ref_rd(a), d, b);
      end
      avs_write = 1'b0;
   endtask

   task automatic drain();
      int ok;
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int racc;
      int wacc;
      int p0;
      int l0;
      int unsigned w;
      int n;
      logic [31:0] d;

      // Reset state, with a request pending to show the stall.
      avs_read = 1'b1;
      #12;
      chk("rst_waitrequest", avs_waitrequest, 1);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b1110);
      chk("rst_be_n", sram_be_n, 4'hF);
      chk("rst_rdv", avs_readdatavalid, 0);
      chk("rst_addr_data", {12'h0, sram_addr} | avs_readdata | sram_dq_o, 0);
      avs_read = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single read with cycle-exact strobe timing.
      do_read(32'h100, 1, acc);
      @(negedge clk);
      chk("t1_c1_addr", sram_addr, 32'h40);
      chk("t1_c1_oe", {sram_ce_n, sram_oe_n}, 0);
      @(negedge clk);
      chk("t1_c2_oe", sram_oe_n, 0);
      @(negedge clk);
      chk("t1_c3_rdv", {avs_readdatavalid, sram_oe_n}, 2'b11);
      chk("t1_c3_data", avs_readdata, 32'hDEADBEEF);
      chk("t1_c3_cycle", cyc - acc, 3);
      drain();

      // 64-beat read burst.
      addr_log.delete();
      p0 = rdv_cnt;
      do_read(32'h1000, 64, acc);
      drain();
      chk("t2_beats", rdv_cnt - p0, 64);
      chk("t2_last_cycle", last_rdv_cyc - acc, 64 * T + 1);
      chk("t2_naddr", addr_log.size(), 64);
      if (addr_log.size() == 64) begin
         chk("t2_first_addr", addr_log[0], 32'h400);
         chk("t2_last_addr", addr_log[63], 32'h43F);
      end

      // 4-beat write with a master stall before beat 2.
      be_log.delete();
      p0 = we_pulses;
      l0 = we_low;
      be_plan = '{4'hF, 4'hF, 4'h3, 4'hF};
      do_write(32'h1800, 4, 2, 3, acc);
      drain();
      chk("t3_pulses", we_pulses - p0, 4);
      chk("t3_we_low", we_low - l0, 4 * T);
      if (be_log.size() == 4) begin
         chk("t3_be0", be_log[0], 4'h0);
         chk("t3_be1", be_log[1], 4'h0);
         chk("t3_be2", be_log[2], 4'hC);
         chk("t3_be3", be_log[3], 4'h0);
      end
      do_read(32'h1800, 4, acc);
      drain();

      // Read burst wrapping the top of the SRAM.
      addr_log.delete();
      do_read(32'h003F_FFF8, 4, acc);
      drain();
      chk("t4_naddr", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         chk("t4_a0", addr_log[0], 32'hFFFFE);
         chk("t4_a1", addr_log[1], 32'hFFFFF);
         chk("t4_a2", addr_log[2], 32'h00000);
         chk("t4_a3", addr_log[3], 32'h00001);
      end

      // Reset during the write pulse of beat 2.
      avs_address = 32'h0002_0000;
      avs_burstcount = 7'd4;
      avs_byteenable = 4'hF;
      avs_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         avs_writedata = $urandom;
         wait_accept(acc);
      end
      chk("t5_pre_we", sram_we_n, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_we_n", sram_we_n, 1);
      chk("t5_dq_oe", sram_dq_oe, 0);
      chk("t5_ce_n", sram_ce_n, 1);
      chk("t5_waitrequest", avs_waitrequest, 1);
      avs_write = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      p0 = rdv_cnt;
      do_read(32'h0, 1, acc);
      drain();
      chk("t5_read_after", rdv_cnt - p0, 1);

      // Simultaneous read and write: read first, write waits.
      w = 32'h700;
      for (int i = 0; i < 2; i++) exp_q.push_back(ref_rd(w + i));
      d = $urandom;
      avs_address = 32'h1C00;
      avs_burstcount = 7'd2;
      avs_writedata = d;
      avs_byteenable = 4'hF;
      avs_read = 1'b1;
      avs_write = 1'b1;
      wait_accept(racc);
      avs_read = 1'b0;
      avs_burstcount = 7'd1;
      wait_accept(wacc);
      avs_write = 1'b0;
      ref_mem[w] = d;
      chk("t6_write_delay", wacc - racc, 2 * T + 1 + TURN_CYC);
      do_read(32'h1C00, 1, acc);
      drain();

      // Randomized mix of bursts over a small shared window.
      for (int k = 0; k < 40; k++) begin
         w = 32'h100 + $urandom_range(0, 255);
         n = $urandom_range(0, 8);
         if ($urandom_range(0, 1) == 1)
            do_read((w << 2) | $urandom_range(0, 3), n, acc);
         else
            do_write((w << 2) | $urandom_range(0, 3), n,
                     $urandom_range(1, 8), $urandom_range(0, 3), acc);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();

      foreach (ref_mem[a]) chk("mem_final", sram_cur(a), ref_mem[a]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
